dram_req_bridge: RTL and testbench

DRAM_REQ_BRIDGE -- requirements
Module: dram_req_bridge

---
 rtl/dram_req_bridge_if.sv | 22 ++
 rtl/dram_req_bridge.sv | 167 ++++++++++++++++
 tb/tb_dram_req_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_req_bridge_if.sv
// Memory-side command/response bus of the DRAM request bridge.
// The master drives commands and consumes read responses.
interface dram_req_bridge_if;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_we;
  logic [31:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [3:0]  mem_cmd_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, mem_cmd_wstrb,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, mem_cmd_wstrb,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/dram_req_bridge.sv
// Converts one-cycle byte/half/word load-store triggers into a single word-wide
// memory command, extracts and extends load lanes, and abandons stalled requests.
module dram_req_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        err,
  dram_req_bridge_if.master mem
);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_ctrl;
  logic [1:0]  r_lane;
  logic [31:0] r_odata;
  logic        r_err;
  logic        r_cmd_valid;
  logic        r_cmd_we;
  logic [31:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic [3:0]  r_cmd_wstrb;

  logic        w_trigger;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_reject;
  logic [31:0] w_cmd_wdata;
  logic [3:0]  w_cmd_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_trigger    = w_dram_we_t | w_dram_le;
  assign w_legal      = w_dram_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_misaligned = ((w_dram_ctrl[1:0] == 2'b01) && w_dram_addr[0]) ||
                        ((w_dram_ctrl[1:0] == 2'b10) && (w_dram_addr[1:0] != 2'b00));
  assign w_reject     = !w_legal || w_misaligned;

  assign w_dram_busy  = !RST && ((r_state != IDLE) || w_trigger);
  assign w_dram_odata = r_odata;
  assign err          = r_err;

  assign mem.mem_cmd_valid = r_cmd_valid;
  assign mem.mem_cmd_we    = r_cmd_we;
  assign mem.mem_cmd_addr  = r_cmd_addr;
  assign mem.mem_cmd_wdata = r_cmd_wdata;
  assign mem.mem_cmd_wstrb = r_cmd_wstrb;

  // Store lanes are replicated so the memory only needs the strobes to pick bytes.
  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_cmd_wdata = '0;
    w_cmd_wstrb = '0;
    if (w_dram_we_t) begin
      case (w_dram_ctrl[1:0])
        2'b00: begin
          w_cmd_wstrb = 4'b0001 << w_dram_addr[1:0];
          w_cmd_wdata = {4{w_dram_wdata[7:0]}};
        end
        2'b01: begin
          w_cmd_wstrb = w_dram_addr[1] ? 4'b1100 : 4'b0011;
          w_cmd_wdata = {2{w_dram_wdata[15:0]}};
        end
        default: begin
          w_cmd_wstrb = 4'b1111;
          w_cmd_wdata = w_dram_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = '0;
    case (r_lane)
      2'd0: w_byte = mem.mem_rsp_rdata[7:0];
      2'd1: w_byte = mem.mem_rsp_rdata[15:8];
      2'd2: w_byte = mem.mem_rsp_rdata[23:16];
      2'd3: w_byte = mem.mem_rsp_rdata[31:24];
      default: w_byte = '0;
    endcase
    w_half = r_lane[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
    case (r_ctrl)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = mem.mem_rsp_rdata;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ctrl      <= '0;
      r_lane      <= '0;
      r_odata     <= '0;
      r_err       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_wstrb <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_trigger) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= CMD;
              r_cnt       <= '0;
              r_ctrl      <= w_dram_ctrl;
              r_lane      <= w_dram_addr[1:0];
              r_cmd_valid <= 1'b1;
              r_cmd_we    <= w_dram_we_t;
              r_cmd_addr  <= {w_dram_addr[31:2], 2'b00};
              r_cmd_wdata <= w_cmd_wdata;
              r_cmd_wstrb <= w_cmd_wstrb;
            end
          end
        end
        CMD: begin
          if (mem.mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_cnt       <= r_cnt + 16'd1;
            r_state     <= r_cmd_we ? IDLE : RSP;
          end else if (r_cnt == TIMEOUT) begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b1;
            r_odata     <= '1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RSP: begin
          if (mem.mem_rsp_valid) begin
            r_odata <= w_load_data;
            r_state <= IDLE;
          end else if (r_cnt == TIMEOUT) begin
            r_err   <= 1'b1;
            r_odata <= '1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_req_bridge.sv
// Scoreboard bench for dram_req_bridge: the driver pushes expected commands and
// results from a plain-arithmetic model; a negedge monitor pops and compares.
module tb_dram_req_bridge;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] addr, wdata, odata;
  logic        we_t, le, busy, err;
  logic [2:0]  ctrl;

  dram_req_bridge_if mem_if();

  dram_req_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .w_dram_addr(addr), .w_dram_wdata(wdata), .w_dram_we_t(we_t), .w_dram_le(le),
    .w_dram_ctrl(ctrl), .w_dram_odata(odata), .w_dram_busy(busy), .err(err),
    .mem(mem_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hs;
  } cmd_t;

  typedef struct {
    logic [31:0] odata;
    logic        err;
    int          busy_len;
  } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] m_odata;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_reject(input logic [2:0] c, input logic [31:0] a);
    case (c)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [31:0] v;
    case (c)
      3'b000, 3'b100: begin
        v = (r >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
        if (c == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (r >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
        if (c == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  // dr: cycles ready stays low in CMD; ds: cycles in RSP before the response.
  task automatic do_txn(input logic wr, input logic both, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] c, input int dr,
                        input int ds, input logic [31:0] rd);
    logic rej;
    int   idx, comp, len;
    cmd_t ec;
    res_t er;
    rej = is_reject(c, a);
    idx = wr ? dr : dr + 1 + ds;
    comp = 0;
    if (rej) begin
      m_err       = 1'b1;
      er.busy_len = 1;
      len         = 2;
    end else begin
      ec.we   = wr;
      ec.addr = a & 32'hFFFF_FFFC;
      ec.hs   = (dr <= TO) ? 1 : 0;
      ec.wdata = '0;
      ec.wstrb = '0;
      if (wr) begin
        case (c[1:0])
          2'b00: begin ec.wstrb = 4'(1 << a[1:0]); ec.wdata = {4{wd[7:0]}}; end
          2'b01: begin ec.wstrb = a[1] ? 4'b1100 : 4'b0011; ec.wdata = {2{wd[15:0]}}; end
          default: begin ec.wstrb = 4'b1111; ec.wdata = wd; end
        endcase
      end
      cmd_q.push_back(ec);
      if (idx <= TO) begin
        comp = idx;
        if (!wr) m_odata = load_val(c, a, rd);
        er.busy_len = idx + 2;
      end else begin
        comp = TO;
        m_odata = 32'hFFFF_FFFF;
        m_err = 1'b1;
        er.busy_len = TO + 2;
      end
      len = ((idx > comp) ? idx : comp) + 2;
    end
    er.odata = m_odata;
    er.err   = m_err;
    res_q.push_back(er);

    @(posedge CLK); #1;
    addr = a; wdata = wd; ctrl = c; we_t = wr; le = !wr || both;
    @(posedge CLK); #1;
    we_t = 1'b0; le = 1'b0; addr = $urandom; wdata = $urandom; ctrl = 3'($urandom);
    for (int cyc = 0; cyc < len; cyc++) begin
      mem_if.mem_cmd_ready = (cyc == dr) || (cyc > dr && $urandom_range(1) == 1);
      if (!rej && !wr && cyc > dr && cyc <= comp) begin
        mem_if.mem_rsp_valid = (cyc == idx);
        mem_if.mem_rsp_rdata = (cyc == idx) ? rd : $urandom;
      end else begin
        mem_if.mem_rsp_valid = (!rej && !wr && cyc == idx) || ($urandom_range(1) == 1);
        mem_if.mem_rsp_rdata = (!rej && !wr && cyc == idx) ? rd : $urandom;
      end
      @(posedge CLK); #1;
    end
    mem_if.mem_cmd_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
  endtask

  // Load accepted, reset pulsed in RSP with a trigger, then a late response.
  task automatic reset_in_rsp(input logic [31:0] a, input logic [31:0] rd);
    cmd_t ec;
    ec.we = 1'b0; ec.addr = a & 32'hFFFF_FFFC; ec.wdata = '0; ec.wstrb = '0; ec.hs = 1;
    cmd_q.push_back(ec);
    @(posedge CLK); #1;
    addr = a; ctrl = 3'b010; le = 1'b1;
    @(posedge CLK); #1;
    le = 1'b0; mem_if.mem_cmd_ready = 1'b1;
    @(posedge CLK); #1;
    mem_if.mem_cmd_ready = 1'b0; RST = 1'b1; le = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; le = 1'b0;
    m_odata = '0; m_err = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_rdata = rd;
    @(posedge CLK); #1;
    mem_if.mem_rsp_valid = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic        prev_busy = 1'b0;
  logic        rst_seen = 1'b0;
  int          hs_cnt = 0;
  int          busy_len = 0;
  logic [31:0] last_odata = '0;
  logic        last_err = 1'b0;

  always @(negedge CLK) begin
    if (mem_if.mem_cmd_valid === 1'b1) begin
      if (cmd_q.size() == 0) begin
        check("cmd_valid_unexpected", 32'(mem_if.mem_cmd_valid), 32'd0);
      end else begin
        check("cmd_we", 32'(mem_if.mem_cmd_we), 32'(cmd_q[0].we));
        check("cmd_addr", mem_if.mem_cmd_addr, cmd_q[0].addr);
        check("cmd_wdata", mem_if.mem_cmd_wdata, cmd_q[0].wdata);
        check("cmd_wstrb", 32'(mem_if.mem_cmd_wstrb), 32'(cmd_q[0].wstrb));
        if (mem_if.mem_cmd_ready === 1'b1) hs_cnt++;
      end
    end
    if (prev_valid && mem_if.mem_cmd_valid !== 1'b1) begin
      if (cmd_q.size() > 0) begin
        check("cmd_handshakes", 32'(hs_cnt), 32'(cmd_q[0].hs));
        void'(cmd_q.pop_front());
      end
      hs_cnt = 0;
    end
    prev_valid = (mem_if.mem_cmd_valid === 1'b1);

    if (RST) begin
      check("busy_in_reset", 32'(busy), 32'd0);
      rst_seen = 1'b1; prev_busy = 1'b0; busy_len = 0;
    end else if (rst_seen) begin
      check("rst_odata", odata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_cmd_valid", 32'(mem_if.mem_cmd_valid), 32'd0);
      check("rst_cmd_we", 32'(mem_if.mem_cmd_we), 32'd0);
      check("rst_cmd_addr", mem_if.mem_cmd_addr, 32'd0);
      check("rst_cmd_wdata", mem_if.mem_cmd_wdata, 32'd0);
      check("rst_cmd_wstrb", 32'(mem_if.mem_cmd_wstrb), 32'd0);
      last_odata = '0; last_err = 1'b0; rst_seen = 1'b0;
      prev_busy = busy; busy_len = busy ? 1 : 0;
    end else if (busy) begin
      busy_len++;
      prev_busy = 1'b1;
    end else if (prev_busy) begin
      if (res_q.size() == 0) begin
        check("result_unexpected", 32'(busy_len), 32'd0);
      end else begin
        check("res_odata", odata, res_q[0].odata);
        check("res_err", 32'(err), 32'(res_q[0].err));
        check("res_busy_len", 32'(busy_len), 32'(res_q[0].busy_len));
        last_odata = res_q[0].odata;
        last_err = res_q[0].err;
        void'(res_q.pop_front());
      end
      prev_busy = 1'b0; busy_len = 0;
    end else begin
      check("idle_odata", odata, last_odata);
      check("idle_err", 32'(err), 32'(last_err));
    end
  end

  initial begin
    logic        wr, both;
    logic [2:0]  c;
    logic [31:0] a;
    int          dr, ds, sel;
    RST = 1'b1; addr = '0; wdata = '0; we_t = 1'b0; le = 1'b0; ctrl = '0;
    mem_if.mem_cmd_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_rdata = '0;
    m_odata = '0; m_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    do_txn(1'b1, 1'b0, 32'h8000_0003, 32'h0000_00A5, 3'b000, 0, 0, '0);
    do_txn(1'b0, 1'b0, 32'h8000_0002, '0, 3'b000, 0, 0, 32'h12F0_3456);
    do_txn(1'b0, 1'b0, 32'h8000_0002, '0, 3'b100, 0, 0, 32'h12F0_3456);
    do_txn(1'b0, 1'b0, 32'h8000_0002, '0, 3'b001, 0, 0, 32'h12F0_3456);
    do_txn(1'b0, 1'b0, 32'h8000_0001, '0, 3'b010, 0, 0, 32'hDEAD_BEEF);
    do_txn(1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 3'b010, 5, 0, '0);
    do_txn(1'b1, 1'b0, 32'h8000_0012, 32'h0000_BEEF, 3'b001, TO, 0, '0);
    do_txn(1'b0, 1'b0, 32'h8000_0020, '0, 3'b010, 0, 10, 32'h0BAD_F00D);
    do_txn(1'b1, 1'b0, 32'h8000_0030, 32'h1111_2222, 3'b010, TO + 2, 0, '0);
    reset_in_rsp(32'h8000_0040, 32'h5555_AAAA);
    do_txn(1'b0, 1'b0, 32'h8000_0044, '0, 3'b010, 1, 1, 32'hCAFE_BABE);
    do_txn(1'b0, 1'b0, 32'h8000_0046, '0, 3'b110, 0, 0, 32'h7777_7777);

    for (int n = 0; n < 250; n++) begin
      wr = ($urandom_range(99) < 40);
      both = wr && ($urandom_range(1) == 1);
      sel = $urandom_range(9);
      if (sel == 9) begin
        case ($urandom_range(2))
          0: c = 3'b011;
          1: c = 3'b110;
          default: c = 3'b111;
        endcase
      end else if (wr) begin
        c = (sel < 3) ? 3'b000 : (sel < 6) ? 3'b001 : 3'b010;
      end else begin
        case (sel % 5)
          0: c = 3'b000;
          1: c = 3'b001;
          2: c = 3'b010;
          3: c = 3'b100;
          default: c = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom_range(3) != 0) begin
        if (c[1:0] == 2'b01) a[0] = 1'b0;
        if (c[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      dr = ($urandom_range(9) == 0) ? $urandom_range(12) : $urandom_range(3);
      ds = ($urandom_range(9) == 0) ? $urandom_range(12) : $urandom_range(3);
      do_txn(wr, both, a, $urandom, c, dr, ds, $urandom);
    end

    repeat (5) @(posedge CLK);
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
